// File: rtl/alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_seq
// Description : Registered, handshaked ALU control decoder. Maps the
//               main-control ALU opcode (plus R-type funct) onto an ALU
//               control code, holds the result under a valid/ready output
//               handshake and sequences multi-cycle MUL/DIV operations with
//               a busy window. Sits between decode and execute.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready   - request handshake (alu_op, funct)
//               out_valid/out_ready - result handshake (alu_ctrl, illegal)
//               busy                - multi-cycle op in progress
//               perf_ops/perf_illegal - accepted / illegal-op counters
// Config      : define ALU_CTRL_PERF_EN to build the saturating performance
//               counters; otherwise both perf outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_seq #(
    parameter int FUNCT_W    = 6,
    parameter int OP_W       = 3,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               illegal,
    output logic               busy,
    output logic [15:0]        perf_ops,
    output logic [15:0]        perf_illegal
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES);

    // The counter is loaded with N-2 and the exit happens on the cycle it
    // reads zero, so the result lands exactly N cycles after the accept.
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 2);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 2);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_MULTI = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [OP_W-1:0] c_OP_ADD  = OP_W'(3'b000);
    localparam logic [OP_W-1:0] c_OP_SUB  = OP_W'(3'b001);
    localparam logic [OP_W-1:0] c_OP_RTYP = OP_W'(3'b010);
    localparam logic [OP_W-1:0] c_OP_AND  = OP_W'(3'b011);
    localparam logic [OP_W-1:0] c_OP_OR   = OP_W'(3'b100);
    localparam logic [OP_W-1:0] c_OP_SLT  = OP_W'(3'b111);

    localparam logic [FUNCT_W-1:0] c_FN_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] c_FN_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] c_FN_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] c_FN_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] c_FN_SLT = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] c_FN_XOR = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] c_FN_NOR = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] c_FN_MUL = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] c_FN_DIV = FUNCT_W'(6'b011010);

    localparam logic [CTRL_W-1:0] c_CTRL_ADD = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] c_CTRL_SUB = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] c_CTRL_AND = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] c_CTRL_OR  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] c_CTRL_SLT = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] c_CTRL_XOR = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] c_CTRL_NOR = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] c_CTRL_MUL = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] c_CTRL_DIV = CTRL_W'(4'b1001);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_out_valid;
    logic [CTRL_W-1:0]   r_alu_ctrl;
    logic                r_illegal;
    logic                r_busy;

    logic [CTRL_W-1:0]   w_dec_ctrl;
    logic                w_dec_illegal;
    logic                w_dec_multi;
    logic [c_CNT_W-1:0]  w_dec_load;
    logic                w_in_ready;
    logic                w_accept;

    // ------------------------------------------------------------------
    // Decoder: fully defined for every input combination. Anything not in
    // the table decodes to ADD with illegal set and runs single-cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_ctrl    = c_CTRL_ADD;
        w_dec_illegal = 1'b0;
        w_dec_multi   = 1'b0;
        w_dec_load    = '0;
        case (alu_op)
            c_OP_ADD: w_dec_ctrl = c_CTRL_ADD;
            c_OP_SUB: w_dec_ctrl = c_CTRL_SUB;
            c_OP_AND: w_dec_ctrl = c_CTRL_AND;
            c_OP_OR:  w_dec_ctrl = c_CTRL_OR;
            c_OP_SLT: w_dec_ctrl = c_CTRL_SLT;
            c_OP_RTYP: begin
                case (funct)
                    c_FN_ADD: w_dec_ctrl = c_CTRL_ADD;
                    c_FN_SUB: w_dec_ctrl = c_CTRL_SUB;
                    c_FN_AND: w_dec_ctrl = c_CTRL_AND;
                    c_FN_OR:  w_dec_ctrl = c_CTRL_OR;
                    c_FN_SLT: w_dec_ctrl = c_CTRL_SLT;
                    c_FN_XOR: w_dec_ctrl = c_CTRL_XOR;
                    c_FN_NOR: w_dec_ctrl = c_CTRL_NOR;
                    c_FN_MUL: begin
                        w_dec_ctrl  = c_CTRL_MUL;
                        w_dec_multi = 1'b1;
                        w_dec_load  = c_MUL_LOAD;
                    end
                    c_FN_DIV: begin
                        w_dec_ctrl  = c_CTRL_DIV;
                        w_dec_multi = 1'b1;
                        w_dec_load  = c_DIV_LOAD;
                    end
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake. In HOLD, in_ready follows out_ready so that a retiring
    // result can be replaced on the same edge (one op per cycle streaming).
    // ------------------------------------------------------------------
    assign w_in_ready = (r_state == c_ST_IDLE) ||
                        ((r_state == c_ST_HOLD) && out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= '0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Accept only happens in IDLE or in HOLD with out_ready, so any
            // held result retires on this same edge.
            r_alu_ctrl <= w_dec_ctrl;
            r_illegal  <= w_dec_illegal;
            if (w_dec_multi) begin
                r_state     <= c_ST_MULTI;
                r_cnt       <= w_dec_load;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b1;
            end else begin
                r_state     <= c_ST_HOLD;
                r_out_valid <= 1'b1;
                r_busy      <= 1'b0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                c_ST_MULTI: begin
                    // Runs to completion regardless of out_ready.
                    if (r_cnt == '0) begin
                        r_state     <= c_ST_HOLD;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign illegal   = r_illegal;
    assign busy      = r_busy;

    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] r_perf_ops;
    logic [15:0] r_perf_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ops     <= 16'h0;
            r_perf_illegal <= 16'h0;
        end else if (w_accept) begin
            if (r_perf_ops != 16'hFFFF) begin
                r_perf_ops <= r_perf_ops + 16'h1;
            end
            if (w_dec_illegal && (r_perf_illegal != 16'hFFFF)) begin
                r_perf_illegal <= r_perf_illegal + 16'h1;
            end
        end
    end

    assign perf_ops     = r_perf_ops;
    assign perf_illegal = r_perf_illegal;
`else
    assign perf_ops     = 16'h0;
    assign perf_illegal = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_seq
// Description : Self-checking bench for alu_control_seq. A transaction-level
//               reference (one in-flight op with a completion cycle number)
//               predicts the handshake and result outputs every cycle;
//               directed scenarios pin literal values, then a randomized
//               phase exercises streaming, back-pressure and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  alu_op    = 3'b000;
    logic [5:0]  funct     = 6'b000000;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  alu_ctrl;
    logic        illegal;
    logic        busy;
    logic [15:0] perf_ops;
    logic [15:0] perf_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_control_seq #(
        .FUNCT_W    (6),
        .OP_W       (3),
        .CTRL_W     (4),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .funct        (funct),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_ctrl     (alu_ctrl),
        .illegal      (illegal),
        .busy         (busy),
        .perf_ops     (perf_ops),
        .perf_illegal (perf_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference: decode table and latency straight from the opcode list.
    // Returns {illegal, ctrl}.
    // ------------------------------------------------------------------
    function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [5:0] fn);
        case (op)
            3'b000: return 5'b0_0000;
            3'b001: return 5'b0_0001;
            3'b011: return 5'b0_0010;
            3'b100: return 5'b0_0011;
            3'b111: return 5'b0_0100;
            3'b010: begin
                case (fn)
                    6'b100000: return 5'b0_0000;
                    6'b100010: return 5'b0_0001;
                    6'b100100: return 5'b0_0010;
                    6'b100101: return 5'b0_0011;
                    6'b101010: return 5'b0_0100;
                    6'b100110: return 5'b0_0110;
                    6'b100111: return 5'b0_0111;
                    6'b011000: return 5'b0_1000;
                    6'b011010: return 5'b0_1001;
                    default:   return 5'b1_0000;
                endcase
            end
            default: return 5'b1_0000;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [5:0] fn);
        if (op == 3'b010 && fn == 6'b011000) return MUL_N;
        if (op == 3'b010 && fn == 6'b011010) return DIV_N;
        return 1;
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: at most one op in flight, visible from cycle
    // number m_done onward, retired by out_ready.
    // ------------------------------------------------------------------
    logic        m_have = 1'b0;
    logic [3:0]  m_ctrl = 4'h0;
    logic        m_ill  = 1'b0;
    int unsigned m_cyc  = 0;
    int unsigned m_done = 0;
    logic [15:0] m_ops  = 16'h0;
    logic [15:0] m_illc = 16'h0;
    logic [4:0]  m_dec;
    int          m_lat;
    logic        m_out_valid;
    logic        m_busy;
    logic        m_in_ready;

    always_comb begin
        m_dec = ref_decode(alu_op, funct);
        m_lat = ref_latency(alu_op, funct);
    end

    assign m_out_valid = m_have && (m_cyc >= m_done);
    assign m_busy      = m_have && (m_cyc < m_done);
    assign m_in_ready  = !m_have || (m_out_valid && out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 1'b0;
            m_ops  <= 16'h0;
            m_illc <= 16'h0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (in_valid && m_in_ready) begin
                m_have <= 1'b1;
                m_ctrl <= m_dec[3:0];
                m_ill  <= m_dec[4];
                m_done <= m_cyc + m_lat;
                if (m_ops != 16'hFFFF) m_ops <= m_ops + 16'h1;
                if (m_dec[4] && m_illc != 16'hFFFF) m_illc <= m_illc + 16'h1;
            end else if (m_out_valid && out_ready) begin
                m_have <= 1'b0;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        chk("model_out_valid", 32'(out_valid), 32'(m_out_valid));
        chk("model_busy",      32'(busy),      32'(m_busy));
        chk("model_in_ready",  32'(in_ready),  32'(m_in_ready));
        if (m_out_valid) begin
            chk("model_alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
            chk("model_illegal",  32'(illegal),  32'(m_ill));
        end
`ifdef ALU_CTRL_PERF_EN
        chk("model_perf_ops",     32'(perf_ops),     32'(m_ops));
        chk("model_perf_illegal", 32'(perf_illegal), 32'(m_illc));
`else
        chk("model_perf_ops",     32'(perf_ops),     32'h0);
        chk("model_perf_illegal", 32'(perf_illegal), 32'h0);
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [2:0] op, input logic [5:0] fn, input logic ordy);
        in_valid  = iv;
        alu_op    = op;
        funct     = fn;
        out_ready = ordy;
    endtask

    logic [2:0] s_ops [5]      = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b111};
    logic [3:0] s_exp [5]      = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    logic [5:0] s_legal_fn [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                   6'b100110, 6'b100111, 6'b011000, 6'b011010};

    initial begin
        // 1. Reset state, then R-type SUB
        drive(1'b0, 3'b000, 6'b000000, 1'b1);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_alu_ctrl",  32'(alu_ctrl),  32'h0);
        chk("rst_illegal",   32'(illegal),   32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_perf_ops",  32'(perf_ops),  32'h0);
        rst_n = 1'b1;
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        drive(1'b1, 3'b010, 6'b100010, 1'b1);
        step();
        in_valid = 1'b0;
        chk("sub_out_valid", 32'(out_valid), 32'h1);
        chk("sub_alu_ctrl",  32'(alu_ctrl),  32'h1);
        chk("sub_illegal",   32'(illegal),   32'h0);
        step();
        chk("sub_retired",   32'(out_valid), 32'h0);

        // 2. MUL then back-to-back DIV
        drive(1'b1, 3'b010, 6'b011000, 1'b1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < MUL_N; k++) begin
            chk("mul_busy",      32'(busy),      32'h1);
            chk("mul_in_ready",  32'(in_ready),  32'h0);
            chk("mul_out_valid", 32'(out_valid), 32'h0);
            step();
        end
        chk("mul_done_valid", 32'(out_valid), 32'h1);
        chk("mul_done_ctrl",  32'(alu_ctrl),  32'h8);
        chk("mul_done_busy",  32'(busy),      32'h0);
        drive(1'b1, 3'b010, 6'b011010, 1'b1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < DIV_N; k++) begin
            chk("div_busy",      32'(busy),      32'h1);
            chk("div_out_valid", 32'(out_valid), 32'h0);
            step();
        end
        chk("div_done_valid", 32'(out_valid), 32'h1);
        chk("div_done_ctrl",  32'(alu_ctrl),  32'h9);
        step();

        // 3. Back-pressure on an ADD while a new request waits
        drive(1'b1, 3'b000, 6'b000000, 1'b0);
        step();
        alu_op = 3'b001;
        for (int k = 0; k < 5; k++) begin
            chk("stall_out_valid", 32'(out_valid), 32'h1);
            chk("stall_alu_ctrl",  32'(alu_ctrl),  32'h0);
            chk("stall_in_ready",  32'(in_ready),  32'h0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stall_released", 32'(out_valid), 32'h0);

        // 4. Streaming single-cycle ops, no bubbles
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, s_ops[i], 6'b000000, 1'b1);
            step();
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk("stream_ctrl",  32'(alu_ctrl),  32'(s_exp[i]));
        end
        in_valid = 1'b0;
        step();

        // 5. Illegal encodings and counters from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 3'b101, 6'b000000, 1'b1);
        step();
        chk("ill1_flag", 32'(illegal),  32'h1);
        chk("ill1_ctrl", 32'(alu_ctrl), 32'h0);
        drive(1'b1, 3'b010, 6'b111111, 1'b1);
        step();
        chk("ill2_flag",  32'(illegal),   32'h1);
        chk("ill2_ctrl",  32'(alu_ctrl),  32'h0);
        chk("ill2_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        step();
`ifdef ALU_CTRL_PERF_EN
        chk("perf_ops_2",     32'(perf_ops),     32'h2);
        chk("perf_illegal_2", 32'(perf_illegal), 32'h2);
`else
        chk("perf_ops_0",     32'(perf_ops),     32'h0);
        chk("perf_illegal_0", 32'(perf_illegal), 32'h0);
`endif

        // 6. Reset two cycles into a DIV
        drive(1'b1, 3'b010, 6'b011010, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("div_pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_busy",  32'(busy),      32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready),  32'h1);
        chk("post_rst_valid",    32'(out_valid), 32'h0);
        chk("post_rst_busy",     32'(busy),      32'h0);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 399) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_op    = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom);
            funct     = ($urandom_range(0, 9) < 7) ? s_legal_fn[$urandom_range(0, 8)]
                                                   : 6'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
